// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU with single-cycle ops, iterative shifts and valid/ready handshakes
module alu_exec_unit #(
   parameter int WIDTH = 32,
   localparam int SA_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SA_W-1:0]  shamt,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   // shift flavour latched at accept: left/0-fill, right/0-fill, right/sign-fill
   localparam logic [1:0] SH_LEFT  = 2'd0;
   localparam logic [1:0] SH_RIGHT = 2'd1;
   localparam logic [1:0] SH_ARITH = 2'd2;

   state_t            state, state_next;
   logic [SA_W-1:0]   cnt;
   logic [1:0]        sdir;
   logic              zero_r, illegal_r;

   logic              is_shift;
   logic              is_illegal;
   logic [SA_W-1:0]   amt;
   logic [1:0]        sdir_in;
   logic [WIDTH-1:0]  alu_res;
   logic [WIDTH-1:0]  shifted;
   logic              accept;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign zero      = zero_r;
   assign illegal   = illegal_r;
   assign accept    = in_valid & in_ready & ~abort;

   // decode the incoming op: shift class, shift amount source, single-cycle result
   always_comb begin
      is_shift   = (op >= 5'd6) && (op <= 5'd11);
      is_illegal = (op >= 5'd12);
      amt        = op[0] ? a[SA_W-1:0] : shamt;
      sdir_in    = SH_LEFT;
      if (op == 5'd8 || op == 5'd9)
         sdir_in = SH_RIGHT;
      else if (op == 5'd10 || op == 5'd11)
         sdir_in = SH_ARITH;
      alu_res = '0;
      case (op)
         5'd0:    alu_res = a + b;
         5'd1:    alu_res = a & b;
         5'd2:    alu_res = a | b;
         5'd3:    alu_res = a - b;
         5'd4:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         5'd5:    alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         default: alu_res = '0;
      endcase
   end

   // one-bit step of the iterative shifter applied to the working result
   always_comb begin
      shifted = {result[WIDTH-2:0], 1'b0};
      if (sdir == SH_RIGHT)
         shifted = {1'b0, result[WIDTH-1:1]};
      else if (sdir == SH_ARITH)
         shifted = {result[WIDTH-1], result[WIDTH-1:1]};
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // next-state logic; abort overrides every transition
   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (is_shift && amt != '0)
                     state_next = SHIFT;
                  else
                     state_next = DONE;
               end
            end
            SHIFT: begin
               if (cnt == SA_W'(1))
                  state_next = DONE;
            end
            DONE: begin
               if (out_ready)
                  state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // datapath: capture on accept, shift while in SHIFT, flags valid only in DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result    <= '0;
         zero_r    <= 1'b0;
         illegal_r <= 1'b0;
         cnt       <= '0;
         sdir      <= SH_LEFT;
      end else if (abort) begin
         cnt       <= '0;
         zero_r    <= 1'b0;
         illegal_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_shift) begin
                     result    <= b;
                     cnt       <= amt;
                     sdir      <= sdir_in;
                     zero_r    <= (amt == '0) && (b == '0);
                     illegal_r <= 1'b0;
                  end else begin
                     result    <= alu_res;
                     zero_r    <= (alu_res == '0);
                     illegal_r <= is_illegal;
                  end
               end
            end
            SHIFT: begin
               result <= shifted;
               cnt    <= cnt - SA_W'(1);
               if (cnt == SA_W'(1))
                  zero_r <= (shifted == '0);
            end
            DONE: begin
               if (out_ready) begin
                  zero_r    <= 1'b0;
                  illegal_r <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed and randomized bench for alu_exec_unit against an arithmetic reference model
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  op = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [4:0]  shamt = '0;
   logic        abort = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .shamt(shamt), .abort(abort),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // reference: result of an op as plain arithmetic on the operands
   function automatic logic [31:0] model_result(input logic [4:0] o, input logic [31:0] x,
                                                 input logic [31:0] y, input logic [4:0] sa);
      int n;
      n = (o == 7 || o == 9 || o == 11) ? int'(x % 32) : int'(sa);
      case (o)
         0:  return x + y;
         1:  return x & y;
         2:  return x | y;
         3:  return x - y;
         4:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         5:  return (x < y) ? 32'd1 : 32'd0;
         6, 7:   return y << n;
         8, 9:   return y >> n;
         10, 11: return 32'($signed(y) >>> n);
         default: return 32'd0;
      endcase
   endfunction

   function automatic int model_latency(input logic [4:0] o, input logic [31:0] x, input logic [4:0] sa);
      if (o >= 6 && o <= 11)
         return ((o % 2 == 1) ? int'(x % 32) : int'(sa)) + 1;
      return 1;
   endfunction

   // called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
   task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] sa, input int hold);
      logic [31:0] er;
      int          el;
      int          lat;
      er = model_result(o, x, y, sa);
      el = model_latency(o, x, sa);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; op = o; a = x; b = y; shamt = sa;
      @(negedge clk);
      in_valid = 1'b0;
      op = 5'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(el));
      check({tag, "_result"}, result, er);
      check({tag, "_zero"}, 32'(zero), 32'(er == 32'd0));
      check({tag, "_illegal"}, 32'(illegal), 32'(o >= 12));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_result"}, result, er);
         check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      check({tag, "_no_out_valid"}, 32'(seen), 32'd0);
   endtask

   initial begin
      logic [4:0]  ro;
      logic [31:0] ra, rb;
      logic [4:0]  rs;

      // reset values
      repeat (2) @(negedge clk);
      check("rst_result", result, 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // directed single-cycle ops
      run_op("add", 5'd0, 32'd5, 32'd7, 5'd0, 0);
      run_op("sub_neg", 5'd3, 32'd3, 32'd5, 5'd0, 0);
      check("sub_neg_value", result, 32'hFFFF_FFFE);
      run_op("sub_zero", 5'd3, 32'd9, 32'd9, 5'd0, 0);
      run_op("slt", 5'd4, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
      run_op("sltu", 5'd5, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
      run_op("and", 5'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 0);
      run_op("or", 5'd2, 32'h0000_0000, 32'h0000_0000, 5'd0, 0);

      // directed shifts
      run_op("sra4", 5'd10, 32'd0, 32'h8000_0000, 5'd4, 0);
      run_op("sllv", 5'd7, 32'h23, 32'd1, 5'd0, 0);
      run_op("srl0", 5'd8, 32'd0, 32'hDEAD_BEEF, 5'd0, 0);
      run_op("srav31", 5'd11, 32'hFFFF_FFFF, 32'h8000_0001, 5'd0, 0);

      // backpressure, then back-to-back accept in the first idle cycle
      run_op("hold", 5'd0, 32'd100, 32'd23, 5'd0, 10);
      run_op("b2b", 5'd0, 32'd1, 32'd2, 5'd0, 0);

      // abort on the 3rd cycle of a long shift
      in_valid = 1'b1; op = 5'd8; a = 32'd0; b = 32'hFFFF_FFFF; shamt = 5'd31;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      expect_quiet("abort", 40);
      run_op("illegal_1f", 5'h1F, 32'd55, 32'd66, 5'd3, 0);

      // reset on the 3rd cycle of a long shift
      in_valid = 1'b1; op = 5'd8; a = 32'd0; b = 32'hFFFF_FFFF; shamt = 5'd31;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_mid_result", result, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid_in_ready", 32'(in_ready), 32'd1);
      expect_quiet("rst_mid", 40);

      // abort together with in_valid: no accept
      in_valid = 1'b1; abort = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1;
      @(negedge clk);
      in_valid = 1'b0; abort = 1'b0;
      check("abort_accept_in_ready", 32'(in_ready), 32'd1);
      expect_quiet("abort_accept", 5);

      // out_ready outside DONE is ignored
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      run_op("after_stray_ready", 5'd6, 32'd0, 32'h0000_0003, 5'd30, 0);

      // randomized ops, including illegal codes and occasional backpressure
      for (int i = 0; i < 60; i++) begin
         ro = 5'($urandom_range(0, 14));
         if (i % 10 == 9) ro = 5'($urandom_range(12, 31));
         ra = $urandom;
         rb = $urandom;
         rs = 5'($urandom);
         if (i % 7 == 0) rb = 32'd0;
         run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, rs, (i % 5 == 0) ? 2 : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
